// File: rtl/sys_bus_pkg.sv
// Shared types and default SoC address map for the system bus controller and decoder.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StResp   = 2'd2,
    StErr    = 2'd3
  } bus_state_e;

  localparam int unsigned SocNumSlaves = 12;
  localparam logic [31:0] SocErrData   = 32'hDEAD_BEEF;

  // Slot order 11..0: spare 0xFFFFxxxx catch-all, memory, VGA, USB DPRAM, DPRAM, hyper-RAM,
  // kbd, sys_ctrl, UART, timer, GPIO, SPI flash.
  localparam logic [32*SocNumSlaves-1:0] SocSlvBase = {
    32'hFFFF_0000, 32'h1000_0000, 32'hFFFD_0000, 32'hFFFE_0000,
    32'h0000_0000, 32'h8000_0000, 32'hFFFF_0500, 32'hFFFF_0400,
    32'hFFFF_0300, 32'hFFFF_0200, 32'hFFFF_0100, 32'h2000_0000
  };

  localparam logic [32*SocNumSlaves-1:0] SocSlvMask = {
    32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hC000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00,
    32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hF000_0000
  };

endpackage

// File: rtl/sys_bus_decode.sv
// Combinational base/mask address match with lowest-index priority; shared with the DMA bus.
module sys_bus_decode
  import sys_bus_pkg::*;
#(
  parameter int unsigned                NUM_SLAVES = SocNumSlaves,
  parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE   = SocSlvBase,
  parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK   = SocSlvMask
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] match_oh_o,
  output logic                  no_match_o
);

  // Scan high to low so the last hit written, the lowest index, wins.
  always_comb begin
    match_oh_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        match_oh_o    = '0;
        match_oh_o[i] = 1'b1;
      end
    end
  end

  assign no_match_o = ~|match_oh_o;

endmodule

// File: rtl/sys_bus_ctrl.sv
// Registered bus controller: per-transaction FSM, ready watchdog, error response and capture.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = SocNumSlaves,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = SocSlvBase,
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = SocSlvMask,
  parameter int unsigned              DEFAULT_SLAVE  = 7,
  parameter int unsigned              TIMEOUT_CYCLES = 1023,
  parameter logic [31:0]              ERR_DATA       = SocErrData
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_addr,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [NUM_SLAVES-1:0]   enables,
  input  logic [NUM_SLAVES-1:0]   slv_ready,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [31:0]             err_addr
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Shifting past the top bit yields zero, i.e. no default slave.
  localparam logic [NUM_SLAVES-1:0] DefaultOh = NUM_SLAVES'(1) << DEFAULT_SLAVE;

  bus_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] enables_q, enables_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] match_oh, sel_oh;
  logic                  no_match, sel_ready, timeout_hit, err_set;
  logic [31:0]           sel_rdata;
  logic [TimerW:0]       timer_inc;

  sys_bus_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .SLV_BASE  (SLV_BASE),
    .SLV_MASK  (SLV_MASK)
  ) u_decode (
    .addr_i    (mem_addr),
    .match_oh_o(match_oh),
    .no_match_o(no_match)
  );

  assign sel_oh      = no_match ? DefaultOh : match_oh;
  assign sel_ready   = |(slv_ready & enables_q);
  assign timer_inc   = {1'b0, timer_q} + (TimerW + 1)'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_inc == (TimerW + 1)'(TIMEOUT_CYCLES));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata |= slv_rdata[32*i +: 32] & {32{enables_q[i]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    enables_d   = enables_q;
    timer_d     = timer_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    err_set     = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_valid) begin
          timer_d = '0;
          if (sel_oh == '0) begin
            state_d     = StErr;
            mem_ready_d = 1'b1;
            mem_rdata_d = ERR_DATA;
            err_set     = 1'b1;
          end else begin
            state_d   = StActive;
            enables_d = sel_oh;
          end
        end
      end
      StActive: begin
        if (!mem_valid) begin
          state_d   = StIdle;
          enables_d = '0;
        end else if (sel_ready) begin
          state_d     = StResp;
          enables_d   = '0;
          mem_ready_d = 1'b1;
          mem_rdata_d = sel_rdata;
        end else if (timeout_hit) begin
          state_d     = StErr;
          enables_d   = '0;
          mem_ready_d = 1'b1;
          mem_rdata_d = ERR_DATA;
          err_set     = 1'b1;
        end else if (!(&timer_q)) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear beats a same-cycle error; otherwise only the first error address is kept.
  always_comb begin
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      bus_err_d = 1'b0;
    end else if (err_set && !bus_err_q) begin
      bus_err_d  = 1'b1;
      err_addr_d = mem_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      enables_q   <= '0;
      timer_q     <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      enables_q   <= enables_d;
      timer_q     <= timer_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign enables   = enables_q;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench: dut_a has DPRAM as default slave, dut_b has no default; both time out after 8.
module tb_sys_bus_ctrl;
  import sys_bus_pkg::*;

  localparam int unsigned N = 12;

  logic           clk = 1'b0;
  logic           resetn, mem_valid, err_clr;
  logic [31:0]    mem_addr;
  logic [N-1:0]   slv_ready;
  logic [32*N-1:0] slv_rdata;

  logic           a_ready, b_ready, a_err, b_err;
  logic [31:0]    a_rdata, b_rdata, a_eaddr, b_eaddr;
  logic [N-1:0]   a_en, b_en;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sys_bus_ctrl #(
    .NUM_SLAVES    (N),
    .DEFAULT_SLAVE (7),
    .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_ready(a_ready),
    .mem_rdata(a_rdata),
    .enables  (a_en),
    .slv_ready(slv_ready),
    .slv_rdata(slv_rdata),
    .err_clr  (err_clr),
    .bus_err  (a_err),
    .err_addr (a_eaddr)
  );

  sys_bus_ctrl #(
    .NUM_SLAVES    (N),
    .DEFAULT_SLAVE (N),
    .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_ready(b_ready),
    .mem_rdata(b_rdata),
    .enables  (b_en),
    .slv_ready(slv_ready),
    .slv_rdata(slv_rdata),
    .err_clr  (err_clr),
    .bus_err  (b_err),
    .err_addr (b_eaddr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] addr);
    mem_addr  = addr;
    mem_valid = 1'b1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    slv_ready = '0;
  endtask

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    err_clr   = 1'b0;
    slv_ready = '0;
    for (int i = 0; i < N; i++) slv_rdata[32*i +: 32] = 32'hA000_0000 | 32'(i);
    slv_rdata[32*3 +: 32] = 32'h1234_5678;

    cyc();
    cyc();
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_en", 32'(a_en), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_eaddr", a_eaddr, 32'h0);
    resetn = 1'b1;
    cyc();

    // UART read, slave ready in cycle 2
    req(32'hFFFF_0300);
    cyc();
    check("rd3_en_c1", 32'(a_en), 32'h008);
    check("rd3_ready_c1", 32'(a_ready), 32'h0);
    cyc();
    check("rd3_en_c2", 32'(a_en), 32'h008);
    slv_ready[3] = 1'b1;
    cyc();
    check("rd3_ready_c3", 32'(a_ready), 32'h1);
    check("rd3_rdata_c3", a_rdata, 32'h1234_5678);
    check("rd3_en_c3", 32'(a_en), 32'h0);
    check("rd3_err", 32'(a_err), 32'h0);
    idle();
    cyc();
    check("rd3_ready_c4", 32'(a_ready), 32'h0);

    // Unmapped: default slave on a, bus error on b
    req(32'h0000_1000);
    cyc();
    check("dflt_en", 32'(a_en), 32'h080);
    check("nodef_ready_c1", 32'(b_ready), 32'h1);
    check("nodef_rdata", b_rdata, 32'hDEAD_BEEF);
    check("nodef_err", 32'(b_err), 32'h1);
    check("nodef_eaddr", b_eaddr, 32'h0000_1000);
    check("nodef_en", 32'(b_en), 32'h0);
    slv_ready[7] = 1'b1;
    cyc();
    check("dflt_ready", 32'(a_ready), 32'h1);
    check("dflt_rdata", a_rdata, 32'hA000_0007);
    check("nodef_idle_gap", 32'(b_ready), 32'h0);
    idle();
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("nodef_clr", 32'(b_err), 32'h0);

    // Clear in the same cycle as a new error wins; a aborts when valid drops
    req(32'h0000_1000);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("clrprio_ready", 32'(b_ready), 32'h1);
    check("clrprio_err", 32'(b_err), 32'h0);
    check("abort_en_c1", 32'(a_en), 32'h080);
    idle();
    cyc();
    check("abort_en", 32'(a_en), 32'h0);
    check("abort_ready", 32'(a_ready), 32'h0);
    check("abort_err", 32'(a_err), 32'h0);

    // Timeout on the timer slave
    req(32'hFFFF_0200);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check($sformatf("to1_en_c%0d", c), 32'(a_en), 32'h004);
      check($sformatf("to1_ready_c%0d", c), 32'(a_ready), 32'h0);
    end
    cyc();
    check("to1_ready_c9", 32'(a_ready), 32'h1);
    check("to1_rdata", a_rdata, 32'hDEAD_BEEF);
    check("to1_en_c9", 32'(a_en), 32'h0);
    check("to1_err", 32'(a_err), 32'h1);
    check("to1_eaddr", a_eaddr, 32'hFFFF_0200);
    idle();
    cyc();
    check("to1_ready_c10", 32'(a_ready), 32'h0);

    // Second timeout keeps the first address
    req(32'hFFFF_0500);
    for (int c = 1; c <= 9; c++) cyc();
    check("to2_ready_c9", 32'(a_ready), 32'h1);
    check("to2_err", 32'(a_err), 32'h1);
    check("to2_eaddr", a_eaddr, 32'hFFFF_0200);
    idle();
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("to_clr", 32'(a_err), 32'h0);

    // Ready in the cycle the timeout would fire
    req(32'hFFFF_0100);
    for (int c = 1; c <= 8; c++) cyc();
    slv_ready[1] = 1'b1;
    cyc();
    check("race_ready", 32'(a_ready), 32'h1);
    check("race_rdata", a_rdata, 32'hA000_0001);
    check("race_err", 32'(a_err), 32'h0);
    idle();
    cyc();

    // Other slaves' ready is ignored, then abort
    req(32'hFFFF_0400);
    cyc();
    slv_ready = 12'hFEF;
    check("ign_en_c1", 32'(a_en), 32'h010);
    cyc();
    check("ign_ready_c2", 32'(a_ready), 32'h0);
    check("ign_en_c2", 32'(a_en), 32'h010);
    cyc();
    check("ign_ready_c3", 32'(a_ready), 32'h0);
    mem_valid = 1'b0;
    cyc();
    check("ign_abort_en", 32'(a_en), 32'h0);
    check("ign_abort_ready", 32'(a_ready), 32'h0);
    cyc();
    check("ign_abort_ready2", 32'(a_ready), 32'h0);
    check("ign_abort_err", 32'(a_err), 32'h0);
    idle();

    // Overlap with the spare window: 0xFFFF0600 only hits slot 11
    req(32'hFFFF_0600);
    cyc();
    check("spare_en", 32'(a_en), 32'h800);
    slv_ready[11] = 1'b1;
    cyc();
    check("spare_ready", 32'(a_ready), 32'h1);
    check("spare_rdata", a_rdata, 32'hA000_000B);
    idle();
    cyc();

    // Asynchronous reset mid-transaction
    req(32'hFFFF_0300);
    cyc();
    check("rstmid_en_c1", 32'(a_en), 32'h008);
    #1 resetn = 1'b0;
    #1;
    check("rstmid_en", 32'(a_en), 32'h0);
    check("rstmid_ready", 32'(a_ready), 32'h0);
    check("rstmid_rdata", a_rdata, 32'h0);
    mem_valid = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    check("rstmid_noresp", 32'(a_ready), 32'h0);
    req(32'hFFFF_0300);
    slv_ready[3] = 1'b1;
    cyc();
    check("post_rst_en", 32'(a_en), 32'h008);
    cyc();
    check("post_rst_ready", 32'(a_ready), 32'h1);
    check("post_rst_rdata", a_rdata, 32'h1234_5678);
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_bus_ctrl.md
# sys_bus_ctrl

Registered, parametrised successor to the SoC's combinational address decoder. It sits between the RV32 core's native memory port and up to NUM_SLAVES peripherals. Each slave's address region is set by base/mask parameters, and lower-index regions win on overlap. It adds a per-transaction FSM, a watchdog timeout, a bus-error response for unmapped or hung accesses, and sticky error capture for the system controller.

## Interface
- NUM_SLAVES, 12: number of slave ports, 1..16.
- SLV_BASE, map from sys_bus_defs.vh: NUM_SLAVES×32 packed vector; slave i base at [32i+31:32i].
- SLV_MASK, map from sys_bus_defs.vh: NUM_SLAVES×32 packed vector; slave i matches when (mem_addr & MASK_i) == BASE_i.
- DEFAULT_SLAVE, 7: slave index taking unmatched addresses; value NUM_SLAVES means no default, so unmatched accesses error.
- TIMEOUT_CYCLES, 1023: cycles waited for slave ready; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an error.

Ports:
- clk  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  core request; held until mem_ready.
- mem_addr  in  32  request address; stable while mem_valid.
- mem_ready  out  1  one-cycle completion pulse to the core.
- mem_rdata  out  32  registered read data, valid while mem_ready=1.
- enables  out  NUM_SLAVES  one-hot slave select, registered.
- slv_ready  in  NUM_SLAVES  per-slave ready.
- slv_rdata  in  NUM_SLAVES×32  packed per-slave read data.
- err_clr  in  1  clears bus_err; single-cycle pulse.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  address of the first uncleared error.

Write data and strobes go from the core straight to the slaves and do not pass through this block.

## Operation
- FSM states are IDLE, ACTIVE, RESP and ERR.
- IDLE: when mem_valid=1, decode mem_addr, register the one-hot select, clear the timer, and move to ACTIVE. If there is no match and DEFAULT_SLAVE=NUM_SLAVES, move to ERR instead with enables left at 0.
- ACTIVE: enables holds the selected bit.
  - Only the selected slave's slv_ready is sampled; ready from any other slave is ignored.
  - On ready: latch that slave's rdata, drop enables, move to RESP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES (and it is nonzero), drop enables and move to ERR.
- RESP: mem_ready=1 for exactly one cycle with the latched data, then IDLE.
- ERR: mem_ready=1 for one cycle with mem_rdata=ERR_DATA, then IDLE.
  - If bus_err=0, set bus_err and capture err_addr.
  - If bus_err is already set, keep the first address.
- If mem_valid drops in ACTIVE (abort), drop enables, go to IDLE, no mem_ready, no error.
- err_clr has priority over a same-cycle error set: bus_err is cleared and the new error is not recorded.
- Decode priority: lowest matching index wins. DEFAULT_SLAVE applies only when nothing matches.
- Timer width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

## Timing
- Reset values: state=IDLE, mem_ready=0, mem_rdata=0, enables=0, bus_err=0, err_addr=0, timer=0.
- Request accepted in cycle 0; enables is high from cycle 1.
- Slave ready in cycle k≥1 gives mem_ready in cycle k+1, so the minimum latency is 2 cycles from mem_valid.
- Unmapped access with no default: mem_ready in cycle 1.
- Timeout: mem_ready in cycle TIMEOUT_CYCLES+1.
- After any mem_ready the FSM spends at least one cycle in IDLE. A core holding mem_valid continuously is re-decoded on the cycle after mem_ready.
- Slave ready that arrives in the same cycle the timeout fires: ready wins, normal response.
- Reset asserted mid-transaction: all outputs return immediately to their reset values, and no response is produced.

## Structure
- sys_bus_defs.vh holds:
  - state encodings;
  - the default SoC map constants (SPI flash, GPIO, timer, UART, sys_ctrl, kbd, hyper-RAM, DPRAM, USB DPRAM, VGA, memory);
  - ERR_DATA.
- Sub-module sys_bus_decode: a purely combinational base/mask match with a priority encoder. It outputs a one-hot match and a no-match flag, and is reused by the future DMA bus.
- sys_bus_ctrl holds the FSM, timer, response register and error capture.

## Test plan
- Read slave 3 (base 0xFFFF0300, mask 0xFFFFFF00) with slv_ready asserted 2 cycles after enables[3] and rdata 0x12345678 -> enables=0x008 for 2 cycles; mem_ready in cycle 3 with 0x12345678; bus_err=0.
- Address 0x00001000 with DEFAULT_SLAVE=7 -> enables[7] set; data from slave 7 returned.
- Same address with DEFAULT_SLAVE=NUM_SLAVES -> mem_ready in cycle 1 with 0xDEADBEEF; bus_err=1; err_addr=0x00001000.
- TIMEOUT_CYCLES=8 and slave never ready -> enables drops and mem_ready+ERR_DATA arrive in cycle 9.
  - A second timeout at a new address leaves err_addr unchanged.
  - err_clr then clears bus_err.
- Non-selected slave pulses ready while selected slave is silent -> no response. Then mem_valid drops -> return to IDLE, no mem_ready, bus_err unchanged.
- resetn asserted in ACTIVE -> enables=0 immediately; no response; the next request completes normally.
